// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time IMEM loader: FSM states and frame geometry.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int unsigned HDR_BYTES      = 4;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler, shared by the header count and the payload words.
// next_word is the word as it would look with byte_in shifted in; word_full flags that
// the byte being shifted this cycle completes a word.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] next_word,
    output logic        word_full
);

    logic [23:0] acc;
    logic [1:0]  count;

    assign next_word = {byte_in, acc};
    assign word_full = shift_en && (count == 2'(BYTES_PER_WORD - 1));

    // Shift accepted bytes in from the top; the byte counter wraps every word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (shift_en) begin
            acc   <= next_word[31:8];
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: receives a framed byte stream (LE word count, payload words,
// XOR checksum), writes the words into IMEM and releases the core only on a good image.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned IMEM_SIZE     = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     restart,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_waddr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] words_loaded
);

    state_t                   state, state_next;
    logic                     accept;
    logic                     shift_en;
    logic                     rearm;
    logic [31:0]              next_word;
    logic                     word_full;
    logic [ADDRESS_WIDTH-1:0] n_words;
    logic [7:0]               csum_acc;

    assign in_ready = (state == HDR) || (state == LOAD) || (state == CSUM);
    assign accept   = in_valid && in_ready;
    assign shift_en = accept && ((state == HDR) || (state == LOAD));
    assign rearm    = restart && ((state == DONE) || (state == ERR));

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (rearm),
        .shift_en  (shift_en),
        .byte_in   (in_data),
        .next_word (next_word),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: header size check, payload completion, checksum verdict, re-arm.
    always_comb begin
        state_next = state;
        case (state)
            HDR: begin
                if (word_full) begin
                    if (next_word == 32'd0) begin
                        state_next = CSUM;
                    end else if (next_word > 32'(IMEM_SIZE)) begin
                        state_next = ERR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_full && ((words_loaded + ADDRESS_WIDTH'(1)) == n_words)) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = (in_data == csum_acc) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (restart) begin
                    state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    // Datapath: word writes, address/count tracking, running XOR and registered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            n_words      <= '0;
            csum_acc     <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= (state_next == DONE);
            err     <= (state_next == ERR);
            cpu_rst <= (state_next != DONE);
            if ((state == HDR) && word_full) begin
                n_words <= ADDRESS_WIDTH'(next_word);
            end
            if ((state == LOAD) && accept) begin
                csum_acc <= csum_acc ^ in_data;
                if (word_full) begin
                    imem_we      <= 1'b1;
                    imem_waddr   <= {words_loaded[ADDRESS_WIDTH-3:0], 2'b00};
                    imem_wdata   <= DATA_WIDTH'(next_word);
                    words_loaded <= words_loaded + ADDRESS_WIDTH'(1);
                end
            end
            if (rearm) begin
                words_loaded <= '0;
                n_words      <= '0;
                csum_acc     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good/bad checksum, size limits, empty
// image, idle gaps with restart, and asynchronous reset mid-payload.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [31:0] words_loaded;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] payload[$];

    imem_loader #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .IMEM_SIZE     (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .restart      (restart),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every IMEM write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one byte and returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned tries = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1);
        @(negedge clk);
    endtask

    function automatic int unsigned pick_gap(input int unsigned max_gap);
        return (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
    endfunction

    // Header, then the words queued in payload, then the checksum byte.
    task automatic send_frame(input logic [31:0] n, input logic [7:0] csum,
                              input int unsigned max_gap);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], pick_gap(max_gap));
        foreach (payload[k]) begin
            logic [31:0] w;
            w = payload[k];
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], pick_gap(max_gap));
        end
        send_byte(csum, pick_gap(max_gap));
        in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        payload.delete();
    endtask

    task automatic check_frame1(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_cpu_rst"}, cpu_rst, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_words"}, words_loaded, 2);
        check({tag, "_nwr"}, wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], 32'h0);
            check({tag, "_d0"}, wr_data[0], 32'h0000_0013);
            check({tag, "_a1"}, wr_addr[1], 32'h4);
            check({tag, "_d1"}, wr_data[1], 32'h00A0_0093);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        #23;
        check("rst_we", imem_we, 0);
        check("rst_waddr", imem_waddr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_loaded, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready", in_ready, 1);

        // 1: two-word image, good checksum, back-to-back bytes
        clear_log();
        payload.push_back(32'h0000_0013);
        payload.push_back(32'h00A0_0093);
        send_frame(32'd2, 8'h20, 0);
        @(negedge clk);
        check_frame1("t1");
        pulse_restart();
        check("rs1_cpu_rst", cpu_rst, 1);
        check("rs1_done", done, 0);
        check("rs1_ready", in_ready, 1);
        check("rs1_words", words_loaded, 0);

        // 2: same image, bad checksum
        clear_log();
        payload.push_back(32'h0000_0013);
        payload.push_back(32'h00A0_0093);
        send_frame(32'd2, 8'h21, 0);
        @(negedge clk);
        check("t2_err", err, 1);
        check("t2_done", done, 0);
        check("t2_cpu_rst", cpu_rst, 1);
        check("t2_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("t2_cpu_rst_hold", cpu_rst, 1);
        pulse_restart();

        // 3: oversize header rejected on the 4th header byte
        clear_log();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        in_valid = 1'b0;
        check("t3_err", err, 1);
        check("t3_ready", in_ready, 0);
        check("t3_cpu_rst", cpu_rst, 1);
        repeat (2) @(negedge clk);
        check("t3_nwr", wr_addr.size(), 0);
        pulse_restart();

        // 3b: exactly IMEM_SIZE words accepted
        clear_log();
        for (int i = 0; i < 1024; i++) payload.push_back(32'h0);
        send_frame(32'd1024, 8'h00, 0);
        @(negedge clk);
        check("t3b_done", done, 1);
        check("t3b_words", words_loaded, 1024);
        check("t3b_nwr", wr_addr.size(), 1024);
        if (wr_addr.size() != 0) check("t3b_last_addr", wr_addr[wr_addr.size()-1], 32'hFFC);
        pulse_restart();

        // 4: empty image
        clear_log();
        send_frame(32'd0, 8'h00, 0);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_cpu_rst", cpu_rst, 0);
        check("t4_words", words_loaded, 0);
        check("t4_nwr", wr_addr.size(), 0);
        pulse_restart();

        // 5: idle gaps between bytes, then restart and a second image
        clear_log();
        payload.push_back(32'h0000_0013);
        payload.push_back(32'h00A0_0093);
        send_frame(32'd2, 8'h20, 5);
        @(negedge clk);
        check_frame1("t5");
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t5_rs_cpu_rst", cpu_rst, 1);
        check("t5_rs_done", done, 0);
        check("t5_rs_ready", in_ready, 1);
        clear_log();
        payload.push_back(32'hDEAD_BEEF);
        payload.push_back(32'h1234_5678);
        payload.push_back(32'h0000_FFFF);
        send_frame(32'd3, 8'h2A, 2);
        @(negedge clk);
        check("t5b_done", done, 1);
        check("t5b_words", words_loaded, 3);
        check("t5b_nwr", wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            check("t5b_a2", wr_addr[2], 32'h8);
            check("t5b_d0", wr_data[0], 32'hDEAD_BEEF);
            check("t5b_d2", wr_data[2], 32'h0000_FFFF);
        end
        pulse_restart();

        // 6: asynchronous reset after 6 bytes of a frame
        clear_log();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t6_we", imem_we, 0);
        check("t6_waddr", imem_waddr, 0);
        check("t6_wdata", imem_wdata, 0);
        check("t6_cpu_rst", cpu_rst, 1);
        check("t6_words", words_loaded, 0);
        check("t6_done", done, 0);
        check("t6_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_ready", in_ready, 1);
        clear_log();
        payload.push_back(32'h0000_0013);
        payload.push_back(32'h00A0_0093);
        send_frame(32'd2, 8'h20, 0);
        @(negedge clk);
        check_frame1("t6b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
